// File: rtl/tag_cdt_pkg.sv
// Shared definitions for the tag capture controller: state encodings,
// default capture-RAM geometry and read-requester identifiers.
package tag_cdt_pkg;

    localparam int ADDR_W  = 12;    // capture-RAM address width
    localparam int MAX_EVT = 2048;  // records per capture when nevt is 0 or too large
    localparam int EVT_W   = 16;    // event-header counter width
    localparam int NEVT_W  = 12;    // width of the nevt request field

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_CAPTURE    = 2'd2,
        ST_DONE       = 2'd3
    } cap_state_e;

    typedef enum logic {
        REQ_A = 1'b0,   // host readout
        REQ_B = 1'b1    // monitor
    } req_id_e;

endpackage

// File: rtl/tag_rd_arb.sv
// Two-way round-robin read arbiter for the capture RAM. Grants, read enable
// and read address are registered; data valid follows the grant by one cycle
// to line up with the RAM's one-cycle read latency.
module tag_rd_arb #(
    parameter int ADDR_W = tag_cdt_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              req_a_i,
    input  logic              req_b_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic              gnt_a_o,
    output logic              gnt_b_o,
    output logic              ren_o,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              valid_a_o,
    output logic              valid_b_o
);

    import tag_cdt_pkg::*;

    req_id_e           prio_q, prio_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              ren_q, ren_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              valid_a_q, valid_b_q;

    // Pick at most one winner per cycle; the side not granted last has priority.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        ren_d   = 1'b0;
        raddr_d = raddr_q;
        prio_d  = prio_q;
        if (en_i) begin
            if (req_a_i && (!req_b_i || prio_q == REQ_A)) begin
                gnt_a_d = 1'b1;
                ren_d   = 1'b1;
                raddr_d = addr_a_i;
                prio_d  = REQ_B;
            end else if (req_b_i) begin
                gnt_b_d = 1'b1;
                ren_d   = 1'b1;
                raddr_d = addr_b_i;
                prio_d  = REQ_A;
            end
        end
    end

    // Register the grant and RAM controls; valid trails the grant by one cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            prio_q    <= REQ_A;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            ren_q     <= 1'b0;
            raddr_q   <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            ren_q     <= ren_d;
            raddr_q   <= raddr_d;
            valid_a_q <= gnt_a_q;
            valid_b_q <= gnt_b_q;
        end
    end

    assign gnt_a_o   = gnt_a_q;
    assign gnt_b_o   = gnt_b_q;
    assign ren_o     = ren_q;
    assign raddr_o   = raddr_q;
    assign valid_a_o = valid_a_q;
    assign valid_b_o = valid_b_q;

endmodule

// File: rtl/tag_cap_ctrl.sv
// Capture controller: skips a programmed number of fiber event headers, then
// enables the record writer until the requested number of records has been
// written. The capture RAM is read back through a round-robin arbiter that
// only serves requests while no capture is in progress.
module tag_cap_ctrl #(
    parameter int ADDR_W  = tag_cdt_pkg::ADDR_W,
    parameter int MAX_EVT = tag_cdt_pkg::MAX_EVT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [15:0]       start_evt,
    input  logic [11:0]       nevt,
    input  logic              evt_mark,
    input  logic              wr_strobe,
    output logic              cap_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   n_cap,
    input  logic              rd_req_a,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_gnt_a,
    output logic              rd_gnt_b,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              rd_valid_a,
    output logic              rd_valid_b
);

    import tag_cdt_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    cap_state_e        state_q, state_d;
    logic [EVT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic [EVT_W-1:0]  start_q, start_d;
    logic [CNT_W-1:0]  nevt_q, nevt_d;
    logic [CNT_W-1:0]  n_cap_q, n_cap_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  nevt_eff;
    logic              rd_en;

    // Zero or an oversized request both mean a full-length capture.
    assign nevt_eff = (nevt != '0 && int'(nevt) <= MAX_EVT) ? CNT_W'(nevt)
                                                            : CNT_W'(MAX_EVT);

    // Capture sequencing: abort first, then arm / event skip / record count.
    always_comb begin
        state_d   = state_q;
        evt_cnt_d = evt_cnt_q;
        start_d   = start_q;
        nevt_d    = nevt_q;
        n_cap_d   = n_cap_q;
        wr_addr_d = wr_addr_q;
        if (abort) begin
            // n_cap and wr_addr keep the partial-run result for readout.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        evt_cnt_d = '0;
                        wr_addr_d = '0;
                        n_cap_d   = '0;
                        start_d   = start_evt;
                        nevt_d    = nevt_eff;
                        state_d   = ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (evt_mark) begin
                        if (evt_cnt_q == start_q) begin
                            state_d = ST_CAPTURE;
                        end else if (evt_cnt_q != '1) begin
                            evt_cnt_d = evt_cnt_q + EVT_W'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (wr_strobe) begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        n_cap_d   = n_cap_q + CNT_W'(1);
                        if (n_cap_q + CNT_W'(1) == nevt_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Capture state and counters, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            evt_cnt_q <= '0;
            start_q   <= '0;
            nevt_q    <= '0;
            n_cap_q   <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            evt_cnt_q <= evt_cnt_d;
            start_q   <= start_d;
            nevt_q    <= nevt_d;
            n_cap_q   <= n_cap_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign cap_ena = (state_q == ST_CAPTURE);
    assign wr_addr = wr_addr_q;
    assign n_cap   = n_cap_q;
    assign state   = state_q;

    // The RAM write port belongs to the writer while a run is in progress.
    assign rd_en = (state_q == ST_IDLE) || (state_q == ST_DONE);

    tag_rd_arb #(
        .ADDR_W (ADDR_W)
    ) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .en_i      (rd_en),
        .req_a_i   (rd_req_a),
        .req_b_i   (rd_req_b),
        .addr_a_i  (rd_addr_a),
        .addr_b_i  (rd_addr_b),
        .gnt_a_o   (rd_gnt_a),
        .gnt_b_o   (rd_gnt_b),
        .ren_o     (ram_ren),
        .raddr_o   (ram_raddr),
        .valid_a_o (rd_valid_a),
        .valid_b_o (rd_valid_b)
    );

endmodule

// File: tb/tb_tag_cap_ctrl.sv
// Self-checking bench for tag_cap_ctrl. Capture behaviour is checked inline
// in each scenario task; read grants go through a scoreboard queue that the
// scenarios fill and a negedge monitor drains.
module tb_tag_cap_ctrl;

    import tag_cdt_pkg::*;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   start_evt = '0;
    logic [11:0]   nevt = '0;
    logic          evt_mark = 1'b0;
    logic          wr_strobe = 1'b0;
    logic          cap_ena;
    logic [AW-1:0] wr_addr;
    logic [1:0]    state;
    logic [AW:0]   n_cap;
    logic          rd_req_a = 1'b0;
    logic          rd_req_b = 1'b0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          rd_gnt_a, rd_gnt_b, ram_ren;
    logic [AW-1:0] ram_raddr;
    logic          rd_valid_a, rd_valid_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        req_id_e       id;
        logic [AW-1:0] addr;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    rd_exp_t e;
    logic    pend_a = 1'b0;
    logic    pend_b = 1'b0;
    logic    rst_seen = 1'b0;
    logic    mon_en = 1'b0;

    tag_cap_ctrl #(.ADDR_W(AW), .MAX_EVT(2048)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .start_evt  (start_evt),
        .nevt       (nevt),
        .evt_mark   (evt_mark),
        .wr_strobe  (wr_strobe),
        .cap_ena    (cap_ena),
        .wr_addr    (wr_addr),
        .state      (state),
        .n_cap      (n_cap),
        .rd_req_a   (rd_req_a),
        .rd_req_b   (rd_req_b),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_gnt_a   (rd_gnt_a),
        .rd_gnt_b   (rd_gnt_b),
        .ram_ren    (ram_ren),
        .ram_raddr  (ram_raddr),
        .rd_valid_a (rd_valid_a),
        .rd_valid_b (rd_valid_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_seen <= rst;

    // Read scoreboard: every grant must match the head of exp_q, and the
    // matching rd_valid must follow exactly one cycle later unless reset hit.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                pend_a = 1'b0;
                pend_b = 1'b0;
            end
            if (pend_a || pend_b || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
                n_tests++;
                if (rd_valid_a !== pend_a || rd_valid_b !== pend_b) begin
                    n_fail++;
                    $display("FAIL rd_valid got a=%b b=%b exp a=%b b=%b",
                             rd_valid_a, rd_valid_b, pend_a, pend_b);
                end
            end
            pend_a = (rd_gnt_a === 1'b1);
            pend_b = (rd_gnt_b === 1'b1);
            if (rd_gnt_a === 1'b1 || rd_gnt_b === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_gnt_unexpected got a=%b b=%b raddr=%0d exp no grant",
                             rd_gnt_a, rd_gnt_b, ram_raddr);
                end else begin
                    e = exp_q.pop_front();
                    if ({rd_gnt_a, rd_gnt_b, ram_ren, ram_raddr} !==
                        {e.id == REQ_A, e.id == REQ_B, 1'b1, e.addr}) begin
                        n_fail++;
                        $display("FAIL rd_gnt got a=%b b=%b ren=%b raddr=%0d exp id=%s addr=%0d",
                                 rd_gnt_a, rd_gnt_b, ram_ren, ram_raddr, e.id.name(), e.addr);
                    end
                end
            end else if (ram_ren !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ram_ren_no_grant got=%b exp=0", ram_ren);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_tests++; if (cap_ena !== 1'b0) begin n_fail++; $display("FAIL reset_cap_ena got=%b exp=0", cap_ena); end
        n_tests++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        n_tests++; if (n_cap !== '0) begin n_fail++; $display("FAIL reset_n_cap got=%0d exp=0", n_cap); end
        n_tests++;
        if ({rd_gnt_a, rd_gnt_b, ram_ren, rd_valid_a, rd_valid_b} !== 5'b0 || ram_raddr !== '0) begin
            n_fail++;
            $display("FAIL reset_rd got gnt=%b%b ren=%b raddr=%0d valid=%b%b exp all 0",
                     rd_gnt_a, rd_gnt_b, ram_ren, ram_raddr, rd_valid_a, rd_valid_b);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_skip_capture();
        logic [1:0] exp_st;
        start_evt = 16'd3;
        nevt      = 12'd4;
        arm = 1'b1; tick(); arm = 1'b0;
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL c1_arm state got=%0d exp=1", state); end
        for (int i = 1; i <= 5; i++) begin
            evt_mark = 1'b1; tick(); evt_mark = 1'b0;
            exp_st = (i >= 4) ? 2'd2 : 2'd1;
            n_tests++;
            if (state !== exp_st) begin n_fail++; $display("FAIL c1_mark%0d state got=%0d exp=%0d", i, state, exp_st); end
        end
        n_tests++; if (cap_ena !== 1'b1) begin n_fail++; $display("FAIL c1_cap_ena got=%b exp=1", cap_ena); end
        for (int k = 1; k <= 4; k++) begin
            wr_strobe = 1'b1; tick(); wr_strobe = 1'b0;
            n_tests++;
            if (n_cap !== 13'(k) || wr_addr !== 12'(k)) begin
                n_fail++;
                $display("FAIL c1_strobe%0d got n_cap=%0d wr_addr=%0d exp=%0d", k, n_cap, wr_addr, k);
            end
        end
        n_tests++;
        if (state !== 2'd3 || cap_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL c1_done got state=%0d cap_ena=%b exp state=3 cap_ena=0", state, cap_ena);
        end
    endtask

    task automatic test_round_robin();
        rd_addr_a = 12'd5;
        rd_addr_b = 12'd9;
        exp_q.push_back('{REQ_A, 12'd5});
        exp_q.push_back('{REQ_B, 12'd9});
        exp_q.push_back('{REQ_A, 12'd5});
        rd_req_a = 1'b1;
        rd_req_b = 1'b1;
        tick();
        n_tests++;
        if (rd_gnt_a !== 1'b1 || ram_raddr !== 12'd5) begin
            n_fail++;
            $display("FAIL rr_first got gnt_a=%b raddr=%0d exp gnt_a=1 raddr=5", rd_gnt_a, ram_raddr);
        end
        tick();
        tick();
        rd_req_a = 1'b0;
        rd_req_b = 1'b0;
        tick();
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain got %0d pending exp 0", exp_q.size()); end
    endtask

    task automatic test_max_records();
        for (int r = 0; r < 2; r++) begin
            start_evt = 16'd0;
            nevt      = (r == 0) ? 12'd0 : 12'd4095;
            arm = 1'b1; tick(); arm = 1'b0;
            evt_mark = 1'b1; tick(); evt_mark = 1'b0;
            n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL max%0d_start state got=%0d exp=2", r, state); end
            wr_strobe = 1'b1;
            for (int k = 1; k <= 2100; k++) begin
                tick();
                if (k == 2047) begin
                    n_tests++;
                    if (state !== 2'd2 || n_cap !== 13'd2047) begin
                        n_fail++;
                        $display("FAIL max%0d_2047 got state=%0d n_cap=%0d exp state=2 n_cap=2047", r, state, n_cap);
                    end
                end
                if (k == 2048) begin
                    n_tests++;
                    if (state !== 2'd3 || n_cap !== 13'd2048 || cap_ena !== 1'b0) begin
                        n_fail++;
                        $display("FAIL max%0d_2048 got state=%0d n_cap=%0d cap_ena=%b exp 3/2048/0",
                                 r, state, n_cap, cap_ena);
                    end
                end
            end
            wr_strobe = 1'b0;
            n_tests++;
            if (state !== 2'd3 || n_cap !== 13'd2048 || wr_addr !== 12'd2048) begin
                n_fail++;
                $display("FAIL max%0d_after got state=%0d n_cap=%0d wr_addr=%0d exp 3/2048/2048",
                         r, state, n_cap, wr_addr);
            end
        end
    endtask

    task automatic test_read_blocked();
        start_evt = 16'd0;
        nevt      = 12'd2;
        arm = 1'b1; tick(); arm = 1'b0;
        evt_mark = 1'b1; tick(); evt_mark = 1'b0;
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL blk_start0 state got=%0d exp=2", state); end
        rd_addr_a = 12'd7;
        rd_req_a  = 1'b1;
        tick();
        tick();
        tick();
        n_tests++; if (rd_gnt_a !== 1'b0) begin n_fail++; $display("FAIL blk_capture gnt_a got=%b exp=0", rd_gnt_a); end
        wr_strobe = 1'b1;
        tick();
        exp_q.push_back('{REQ_A, 12'd7});
        tick();
        wr_strobe = 1'b0;
        n_tests++;
        if (state !== 2'd3 || rd_gnt_a !== 1'b0) begin
            n_fail++;
            $display("FAIL blk_done got state=%0d gnt_a=%b exp state=3 gnt_a=0", state, rd_gnt_a);
        end
        tick();
        n_tests++;
        if (rd_gnt_a !== 1'b1 || ram_raddr !== 12'd7) begin
            n_fail++;
            $display("FAIL blk_grant got gnt_a=%b raddr=%0d exp gnt_a=1 raddr=7", rd_gnt_a, ram_raddr);
        end
        rd_req_a = 1'b0;
        tick();
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL blk_drain got %0d pending exp 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        start_evt = 16'd0;
        nevt      = 12'd20;
        arm = 1'b1; tick(); arm = 1'b0;
        evt_mark = 1'b1; tick(); evt_mark = 1'b0;
        wr_strobe = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        wr_strobe = 1'b0;
        n_tests++; if (n_cap !== 13'd7) begin n_fail++; $display("FAIL abort_pre n_cap got=%0d exp=7", n_cap); end
        abort = 1'b1; wr_strobe = 1'b1; tick(); abort = 1'b0; wr_strobe = 1'b0;
        n_tests++;
        if (state !== 2'd0 || n_cap !== 13'd7 || cap_ena !== 1'b0 || wr_addr !== 12'd7) begin
            n_fail++;
            $display("FAIL abort got state=%0d n_cap=%0d cap_ena=%b wr_addr=%0d exp 0/7/0/7",
                     state, n_cap, cap_ena, wr_addr);
        end
        abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
        n_tests++;
        if (state !== 2'd0 || n_cap !== 13'd7) begin
            n_fail++;
            $display("FAIL abort_vs_arm got state=%0d n_cap=%0d exp state=0 n_cap=7", state, n_cap);
        end
    endtask

    task automatic test_reset_mid_read();
        rd_addr_a = 12'd3;
        exp_q.push_back('{REQ_A, 12'd3});
        rd_req_a = 1'b1; tick(); rd_req_a = 1'b0;
        n_tests++; if (rd_gnt_a !== 1'b1) begin n_fail++; $display("FAIL rst_pre_grant got=%b exp=1", rd_gnt_a); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if (rd_valid_a !== 1'b0 || rd_gnt_a !== 1'b0 || ram_ren !== 1'b0 || ram_raddr !== '0) begin
            n_fail++;
            $display("FAIL rst_read got valid=%b gnt=%b ren=%b raddr=%0d exp all 0",
                     rd_valid_a, rd_gnt_a, ram_ren, ram_raddr);
        end
        n_tests++;
        if (state !== 2'd0 || n_cap !== '0 || wr_addr !== '0 || cap_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cap got state=%0d n_cap=%0d wr_addr=%0d cap_ena=%b exp all 0",
                     state, n_cap, wr_addr, cap_ena);
        end
        rd_addr_a = 12'd1;
        rd_addr_b = 12'd2;
        exp_q.push_back('{REQ_A, 12'd1});
        rd_req_a = 1'b1; rd_req_b = 1'b1; tick(); rd_req_a = 1'b0; rd_req_b = 1'b0;
        n_tests++;
        if (rd_gnt_a !== 1'b1 || rd_gnt_b !== 1'b0 || ram_raddr !== 12'd1) begin
            n_fail++;
            $display("FAIL rst_prio got gnt=%b%b raddr=%0d exp gnt_a only raddr=1", rd_gnt_a, rd_gnt_b, ram_raddr);
        end
        tick();
        tick();
    endtask

    task automatic test_ignored_inputs();
        wr_strobe = 1'b1; tick(); wr_strobe = 1'b0;
        n_tests++;
        if (state !== 2'd0 || wr_addr !== '0 || n_cap !== '0) begin
            n_fail++;
            $display("FAIL ign_idle_strobe got state=%0d wr_addr=%0d n_cap=%0d exp 0/0/0", state, wr_addr, n_cap);
        end
        start_evt = 16'd1;
        nevt      = 12'd1;
        arm = 1'b1; tick(); arm = 1'b0;
        wr_strobe = 1'b1; tick(); wr_strobe = 1'b0;
        n_tests++;
        if (state !== 2'd1 || wr_addr !== '0) begin
            n_fail++;
            $display("FAIL ign_wait_strobe got state=%0d wr_addr=%0d exp 1/0", state, wr_addr);
        end
        evt_mark = 1'b1; tick(); evt_mark = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        evt_mark = 1'b1; tick(); evt_mark = 1'b0;
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL ign_wait_arm state got=%0d exp=2", state); end
        arm = 1'b1; tick(); arm = 1'b0;
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL ign_cap_arm state got=%0d exp=2", state); end
        wr_strobe = 1'b1; tick(); wr_strobe = 1'b0;
        n_tests++;
        if (state !== 2'd3 || n_cap !== 13'd1 || wr_addr !== 12'd1) begin
            n_fail++;
            $display("FAIL ign_done got state=%0d n_cap=%0d wr_addr=%0d exp 3/1/1", state, n_cap, wr_addr);
        end
        start_evt = 16'd0;
        nevt      = 12'd5;
        arm = 1'b1; tick(); arm = 1'b0;
        n_tests++;
        if (state !== 2'd1 || n_cap !== '0 || wr_addr !== '0) begin
            n_fail++;
            $display("FAIL ign_rearm got state=%0d n_cap=%0d wr_addr=%0d exp 1/0/0", state, n_cap, wr_addr);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL ign_abort_wait state got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_skip_capture();
        test_round_robin();
        test_max_records();
        test_read_blocked();
        test_abort();
        test_reset_mid_read();
        test_ignored_inputs();
        tick();
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_drain got %0d pending exp 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
